// File: rtl/cw_offload_pkg.sv
// cw_offload_pkg: constants and helpers shared by the output stage and the
// decoder core.
//   RESET_VAL : level of the reset input that means "in reset" (active-low)
//   cdiv()    : ceiling divide, used for beat and segment counts
package cw_offload_pkg;

    localparam logic RESET_VAL = 1'b0;

    function automatic int unsigned cdiv(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/cw_offload.sv
// cw_offload: output stage behind the decoder core. Captures one N_V-bit
// hard-decision codeword and serialises it into WIDTH_OUT-bit beats, LSB
// chunk first, under consumer flow control.
// Ports:
//   clk            : rising-edge clock
//   rst            : asynchronous active-low reset
//   cw_in          : decoded codeword, sampled when cw_valid && cw_accept
//   cw_valid       : codeword-present strobe from the decoder core
//   cw_accept      : block can take a codeword this cycle
//   first_data_out : consumer request to start sending the held codeword
//   dout_ready     : consumer accepts the current beat
//   databus_out    : current beat, MSBs of the last beat zero-padded
//   data_valid_out : databus_out holds a valid beat
//   last_out       : current beat is the final one
//   out_ready      : codeword held, waiting for first_data_out
//   cw_drop        : sticky, a codeword arrived while cw_accept was low
module cw_offload
    import cw_offload_pkg::*;
#(
    parameter int unsigned N_V       = 31,
    parameter int unsigned WIDTH_OUT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_V-1:0]       cw_in,
    input  logic                 cw_valid,
    output logic                 cw_accept,
    input  logic                 first_data_out,
    input  logic                 dout_ready,
    output logic [WIDTH_OUT-1:0] databus_out,
    output logic                 data_valid_out,
    output logic                 last_out,
    output logic                 out_ready,
    output logic                 cw_drop
);

    localparam int unsigned N_BEATS = cdiv(N_V, WIDTH_OUT);
    localparam int unsigned SHW     = N_BEATS * WIDTH_OUT;
    localparam int unsigned CNT_W   = $clog2(N_BEATS) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SEND = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [SHW-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             drop_q,  drop_d;

    logic is_last;
    logic xfer;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RESET_VAL) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
        end
    end

    // Beat-facing outputs decode from registers only.
    assign is_last        = (state_q == SEND) && (cnt_q == CNT_W'(N_BEATS - 1));
    assign data_valid_out = (state_q == SEND);
    assign databus_out    = (state_q == SEND) ? shreg_q[WIDTH_OUT-1:0] : '0;
    assign last_out       = is_last;
    assign out_ready      = (state_q == HOLD);
    assign cw_drop        = drop_q;
    assign xfer           = data_valid_out && dout_ready;

    // Accepting during the final transfer lets a new codeword follow without a bubble.
    assign cw_accept = (state_q == IDLE) || (is_last && dout_ready);

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        drop_d  = drop_q;

        case (state_q)
            HOLD: begin
                if (first_data_out) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    shreg_d = shreg_q >> WIDTH_OUT;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (is_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: ;
        endcase

        // A load overrides the SEND update so the back-to-back case starts clean.
        if (cw_valid) begin
            if (cw_accept) begin
                shreg_d = SHW'(cw_in);
                cnt_d   = '0;
                state_d = HOLD;
            end else begin
                drop_d = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cw_offload.sv
module tb_cw_offload;

    logic        clk;
    logic        rst;
    logic [30:0] cw_in;
    logic        cw_valid;
    logic        cw_accept;
    logic        first_data_out;
    logic        dout_ready;
    logic [7:0]  databus_out;
    logic        data_valid_out;
    logic        last_out;
    logic        out_ready;
    logic        cw_drop;

    int errors = 0;
    int checks = 0;

    cw_offload #(.N_V(31), .WIDTH_OUT(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .cw_in          (cw_in),
        .cw_valid       (cw_valid),
        .cw_accept      (cw_accept),
        .first_data_out (first_data_out),
        .dout_ready     (dout_ready),
        .databus_out    (databus_out),
        .data_valid_out (data_valid_out),
        .last_out       (last_out),
        .out_ready      (out_ready),
        .cw_drop        (cw_drop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a codeword in IDLE, expect acceptance, then HOLD next cycle.
    task automatic load_cw(input string tag, input logic [30:0] cw);
        cw_valid = 1'b1;
        cw_in    = cw;
        #1;
        chk({tag, "_accept"}, 32'(cw_accept), 32'd1);
        tick;
        cw_valid = 1'b0;
        chk({tag, "_out_ready"}, 32'(out_ready), 32'd1);
        chk({tag, "_hold_novalid"}, 32'(data_valid_out), 32'd0);
    endtask

    task automatic start_send;
        first_data_out = 1'b1;
        tick;
        first_data_out = 1'b0;
    endtask

    // Check the current beat with dout_ready high, then let it transfer.
    task automatic beat(input string tag, input logic [7:0] exp, input logic exp_last);
        dout_ready = 1'b1;
        chk({tag, "_valid"}, 32'(data_valid_out), 32'd1);
        chk({tag, "_bus"}, 32'(databus_out), 32'(exp));
        chk({tag, "_last"}, 32'(last_out), 32'(exp_last));
        chk({tag, "_out_ready"}, 32'(out_ready), 32'd0);
        tick;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_valid"}, 32'(data_valid_out), 32'd0);
        chk({tag, "_out_ready"}, 32'(out_ready), 32'd0);
        chk({tag, "_accept"}, 32'(cw_accept), 32'd1);
    endtask

    initial begin
        rst            = 1'b0;
        cw_in          = '0;
        cw_valid       = 1'b0;
        first_data_out = 1'b0;
        dout_ready     = 1'b1;
        tick;
        tick;
        chk("rst_accept", 32'(cw_accept), 32'd1);
        chk("rst_valid", 32'(data_valid_out), 32'd0);
        chk("rst_bus", 32'(databus_out), 32'd0);
        chk("rst_last", 32'(last_out), 32'd0);
        chk("rst_out_ready", 32'(out_ready), 32'd0);
        chk("rst_drop", 32'(cw_drop), 32'd0);
        rst = 1'b1;
        tick;

        // 1. Basic
        load_cw("t1", 31'h5A5A1234);
        start_send;
        beat("t1_b0", 8'h34, 1'b0);
        beat("t1_b1", 8'h12, 1'b0);
        beat("t1_b2", 8'h5A, 1'b0);
        beat("t1_b3", 8'h5A, 1'b1);
        check_idle("t1_end");

        // 2. Backpressure on beat 1
        load_cw("t2", 31'h5A5A1234);
        start_send;
        beat("t2_b0", 8'h34, 1'b0);
        dout_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t2_stall_bus", 32'(databus_out), 32'h12);
            chk("t2_stall_valid", 32'(data_valid_out), 32'd1);
            tick;
        end
        beat("t2_b1", 8'h12, 1'b0);
        beat("t2_b2", 8'h5A, 1'b0);
        beat("t2_b3", 8'h5A, 1'b1);
        check_idle("t2_end");

        // 3. Padding of the last beat
        load_cw("t3", 31'h7FFFFFFF);
        start_send;
        beat("t3_b0", 8'hFF, 1'b0);
        beat("t3_b1", 8'hFF, 1'b0);
        beat("t3_b2", 8'hFF, 1'b0);
        beat("t3_b3", 8'h7F, 1'b1);

        // 4. Drop while holding, first_data_out ignored in IDLE
        chk("t4_drop_before", 32'(cw_drop), 32'd0);
        load_cw("t4", 31'h5A5A1234);
        cw_valid = 1'b1;
        cw_in    = 31'h1;
        #1;
        chk("t4_hold_accept", 32'(cw_accept), 32'd0);
        tick;
        cw_valid = 1'b0;
        chk("t4_drop", 32'(cw_drop), 32'd1);
        chk("t4_still_hold", 32'(out_ready), 32'd1);
        start_send;
        beat("t4_b0", 8'h34, 1'b0);
        beat("t4_b1", 8'h12, 1'b0);
        beat("t4_b2", 8'h5A, 1'b0);
        beat("t4_b3", 8'h5A, 1'b1);
        first_data_out = 1'b1;
        tick;
        first_data_out = 1'b0;
        check_idle("t4_ignore_first");
        chk("t4_drop_sticky", 32'(cw_drop), 32'd1);

        // 5. Back-to-back load during the final transfer
        load_cw("t5", 31'h5A5A1234);
        start_send;
        beat("t5_b0", 8'h34, 1'b0);
        beat("t5_b1", 8'h12, 1'b0);
        beat("t5_b2", 8'h5A, 1'b0);
        chk("t5_b3_bus", 32'(databus_out), 32'h5A);
        chk("t5_b3_last", 32'(last_out), 32'd1);
        cw_valid = 1'b1;
        cw_in    = 31'h0000ABCD;
        #1;
        chk("t5_b2b_accept", 32'(cw_accept), 32'd1);
        tick;
        cw_valid = 1'b0;
        chk("t5_b2b_out_ready", 32'(out_ready), 32'd1);
        chk("t5_b2b_valid", 32'(data_valid_out), 32'd0);
        start_send;
        beat("t5_c0", 8'hCD, 1'b0);
        beat("t5_c1", 8'hAB, 1'b0);
        beat("t5_c2", 8'h00, 1'b0);
        beat("t5_c3", 8'h00, 1'b1);

        // 6. Reset in the middle of SEND
        load_cw("t6", 31'h5A5A1234);
        start_send;
        beat("t6_b0", 8'h34, 1'b0);
        beat("t6_b1", 8'h12, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(data_valid_out), 32'd0);
        chk("t6_rst_bus", 32'(databus_out), 32'd0);
        chk("t6_rst_last", 32'(last_out), 32'd0);
        chk("t6_rst_out_ready", 32'(out_ready), 32'd0);
        chk("t6_rst_accept", 32'(cw_accept), 32'd1);
        chk("t6_rst_drop", 32'(cw_drop), 32'd0);
        tick;
        #4;
        rst = 1'b1;
        tick;
        check_idle("t6_after");
        load_cw("t6n", 31'h0000ABCD);
        start_send;
        beat("t6_c0", 8'hCD, 1'b0);
        beat("t6_c1", 8'hAB, 1'b0);
        beat("t6_c2", 8'h00, 1'b0);
        beat("t6_c3", 8'h00, 1'b1);
        check_idle("t6_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
